// File: rtl/csr_trap_unit.sv
// Machine-mode CSR file with illegal-instruction and external-interrupt trap sequencing.
// Build option: define CSR_IRQ_EN to enable the interrupt path and the mie register.
module csr_trap_unit (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        stall_i,
  input  logic        csr_we_i,
  input  logic [2:0]  csr_op_i,
  input  logic [11:0] csr_addr_i,
  input  logic [31:0] wd_i,
  input  logic [31:0] pc_i,
  input  logic        illegal_instr_i,
  input  logic        mret_i,
  input  logic        irq_req_i,
  output logic [31:0] read_data_o,
  output logic [31:0] mepc_o,
  output logic [31:0] trap_pc_o,
  output logic        trap_o,
  output logic        irq_ack_o
);

  localparam logic [11:0] ADDR_MIE      = 12'h304;
  localparam logic [11:0] ADDR_MTVEC    = 12'h305;
  localparam logic [11:0] ADDR_MSCRATCH = 12'h340;
  localparam logic [11:0] ADDR_MEPC     = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE   = 12'h342;

  localparam logic [31:0] CAUSE_ILLEGAL = 32'h0000_0002;
  localparam logic [31:0] CAUSE_IRQ     = 32'h8000_0010;

  typedef enum logic [0:0] {
    RUN     = 1'b0,
    HANDLER = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] mtvec_q, mtvec_d;
  logic [31:0] mscratch_q, mscratch_d;
  logic [31:0] mepc_q, mepc_d;
  logic [31:0] mcause_q, mcause_d;
  logic [31:0] mie_val;

  logic        illegal_trap;
  logic        irq_trap;
  logic        trap;
  logic        mret_take;
  logic        csr_commit;
  logic [31:0] old_val;
  logic [31:0] new_val;

  // funct3[2] only selects the operand source upstream
  logic        unused_op2;
  assign unused_op2 = csr_op_i[2];

`ifdef CSR_IRQ_EN
  logic [31:0] mie_q, mie_d;
  assign mie_val  = mie_q;
  assign irq_trap = (state_q == RUN) & irq_req_i & mie_q[16] & ~stall_i
                    & ~illegal_instr_i & ~mret_i;
`else
  logic        unused_irq;
  assign unused_irq = irq_req_i;
  assign mie_val    = '0;
  assign irq_trap   = 1'b0;
`endif

  assign illegal_trap = illegal_instr_i & ~stall_i;
  assign trap         = illegal_trap | irq_trap;
  assign mret_take    = (state_q == HANDLER) & mret_i & ~stall_i & ~illegal_instr_i;
  assign csr_commit   = csr_we_i & ~stall_i & ~illegal_instr_i & ~trap
                        & (csr_op_i[1:0] != 2'b00);

  always_comb begin
    old_val = '0;
    case (csr_addr_i)
      ADDR_MIE:      old_val = mie_val;
      ADDR_MTVEC:    old_val = mtvec_q;
      ADDR_MSCRATCH: old_val = mscratch_q;
      ADDR_MEPC:     old_val = mepc_q;
      ADDR_MCAUSE:   old_val = mcause_q;
      default:       old_val = '0;
    endcase
  end

  always_comb begin
    new_val = old_val;
    case (csr_op_i[1:0])
      2'b01:   new_val = wd_i;
      2'b10:   new_val = old_val | wd_i;
      2'b11:   new_val = old_val & ~wd_i;
      default: new_val = old_val;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    mtvec_d    = mtvec_q;
    mscratch_d = mscratch_q;
    mepc_d     = mepc_q;
    mcause_d   = mcause_q;
`ifdef CSR_IRQ_EN
    mie_d      = mie_q;
`endif
    if (csr_commit) begin
      case (csr_addr_i)
`ifdef CSR_IRQ_EN
        ADDR_MIE:      mie_d      = new_val;
`endif
        ADDR_MTVEC:    mtvec_d    = new_val;
        ADDR_MSCRATCH: mscratch_d = new_val;
        ADDR_MEPC:     mepc_d     = new_val;
        ADDR_MCAUSE:   mcause_d   = new_val;
        default:       ;
      endcase
    end
    // trap capture overrides any same-cycle CSR write (csr_commit is already masked)
    if (trap) begin
      mepc_d   = pc_i;
      mcause_d = illegal_trap ? CAUSE_ILLEGAL : CAUSE_IRQ;
      state_d  = HANDLER;
    end else if (mret_take) begin
      state_d  = RUN;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= RUN;
      mtvec_q    <= '0;
      mscratch_q <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
`ifdef CSR_IRQ_EN
      mie_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      mtvec_q    <= mtvec_d;
      mscratch_q <= mscratch_d;
      mepc_q     <= mepc_d;
      mcause_q   <= mcause_d;
`ifdef CSR_IRQ_EN
      mie_q      <= mie_d;
`endif
    end
  end

  // gating with rst_ni drops the trap strobes immediately on async reset
  assign trap_o      = trap & rst_ni;
  assign irq_ack_o   = irq_trap & rst_ni;
  assign read_data_o = old_val;
  assign mepc_o      = mepc_q;
  assign trap_pc_o   = mtvec_q;

endmodule

// File: tb/tb_csr_trap_unit.sv
// Directed bench for csr_trap_unit; covers both the default and CSR_IRQ_EN builds.
module tb_csr_trap_unit;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        stall_i, csr_we_i, illegal_instr_i, mret_i, irq_req_i;
  logic [2:0]  csr_op_i;
  logic [11:0] csr_addr_i;
  logic [31:0] wd_i, pc_i;
  logic [31:0] read_data_o, mepc_o, trap_pc_o;
  logic        trap_o, irq_ack_o;

  int vectors = 0;
  int miscompares = 0;

  csr_trap_unit dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .stall_i(stall_i), .csr_we_i(csr_we_i),
    .csr_op_i(csr_op_i), .csr_addr_i(csr_addr_i), .wd_i(wd_i), .pc_i(pc_i),
    .illegal_instr_i(illegal_instr_i), .mret_i(mret_i), .irq_req_i(irq_req_i),
    .read_data_o(read_data_o), .mepc_o(mepc_o), .trap_pc_o(trap_pc_o),
    .trap_o(trap_o), .irq_ack_o(irq_ack_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    stall_i = 0; csr_we_i = 0; csr_op_i = 3'b000; csr_addr_i = 12'h000;
    wd_i = 0; pc_i = 0; illegal_instr_i = 0; mret_i = 0; irq_req_i = 0;
  endtask

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic csr_wr(input logic [2:0] op, input logic [11:0] addr, input logic [31:0] wd);
    idle();
    csr_we_i = 1; csr_op_i = op; csr_addr_i = addr; wd_i = wd;
    cyc();
    idle();
  endtask

  task automatic rd(input string tag, input logic [11:0] addr, input logic [31:0] exp);
    csr_addr_i = addr;
    #1;
    chk(tag, read_data_o, exp);
  endtask

  task automatic chk_state(input string tag, input logic exp);
    chk(tag, {31'b0, dut.state_q}, {31'b0, exp});
  endtask

  initial begin
    idle();
    rst_ni = 0;
    #12;
    chk("rst_trap", {31'b0, trap_o}, 32'h0);
    chk("rst_ack", {31'b0, irq_ack_o}, 32'h0);
    chk("rst_mepc", mepc_o, 32'h0);
    chk("rst_mtvec", trap_pc_o, 32'h0);
    rd("rst_mcause", 12'h342, 32'h0);
    chk_state("rst_state", 1'b0);
    rst_ni = 1;
    cyc();

    // mtvec write / set / clear
    csr_wr(3'b001, 12'h305, 32'h0000_0100);
    chk("mtvec_wr", trap_pc_o, 32'h100);
    idle(); csr_we_i = 1; csr_op_i = 3'b010; csr_addr_i = 12'h305; wd_i = 32'h3;
    #1;
    chk("mtvec_old", read_data_o, 32'h100);
    cyc(); idle();
    chk("mtvec_set", trap_pc_o, 32'h103);
    csr_wr(3'b011, 12'h305, 32'h1);
    chk("mtvec_clr", trap_pc_o, 32'h102);

    // stalled write, then real write, then op 00 no-write
    idle(); stall_i = 1; csr_we_i = 1; csr_op_i = 3'b001; csr_addr_i = 12'h340; wd_i = 32'h1234_5678;
    cyc(); idle();
    rd("mscr_stall", 12'h340, 32'h0);
    csr_wr(3'b001, 12'h340, 32'h1234_5678);
    rd("mscr_wr", 12'h340, 32'h1234_5678);
    csr_wr(3'b000, 12'h340, 32'hFFFF_FFFF);
    rd("mscr_op00", 12'h340, 32'h1234_5678);
    rd("unmapped", 12'h300, 32'h0);

    // illegal trap beats a same-cycle mepc write
    idle(); illegal_instr_i = 1; pc_i = 32'h40;
    csr_we_i = 1; csr_op_i = 3'b001; csr_addr_i = 12'h341; wd_i = 32'h999;
    #1;
    chk("ill_trap", {31'b0, trap_o}, 32'h1);
    chk("ill_ack", {31'b0, irq_ack_o}, 32'h0);
    cyc(); idle();
    chk("ill_mepc", mepc_o, 32'h40);
    rd("ill_mcause", 12'h342, 32'h2);
    chk_state("ill_state", 1'b1);

    // mret: stalled has no effect, then returns to RUN
    idle(); mret_i = 1; stall_i = 1;
    cyc();
    chk_state("mret_stall", 1'b1);
    stall_i = 0;
    #1;
    chk("mret_notrap", {31'b0, trap_o}, 32'h0);
    cyc(); idle();
    chk_state("mret_run", 1'b0);
    chk("mret_mepc", mepc_o, 32'h40);
    mret_i = 1;
    cyc(); idle();
    chk_state("mret_in_run", 1'b0);

`ifdef CSR_IRQ_EN
    csr_wr(3'b001, 12'h304, 32'h0001_0000);
    rd("mie_wr", 12'h304, 32'h0001_0000);
    idle(); irq_req_i = 1; pc_i = 32'h80;
    #1;
    chk("irq_trap", {31'b0, trap_o}, 32'h1);
    chk("irq_ack", {31'b0, irq_ack_o}, 32'h1);
    cyc();
    pc_i = 32'h84;
    #1;
    chk("irq_nest_trap", {31'b0, trap_o}, 32'h0);
    chk("irq_nest_ack", {31'b0, irq_ack_o}, 32'h0);
    chk("irq_mepc", mepc_o, 32'h80);
    rd("irq_mcause", 12'h342, 32'h8000_0010);
    cyc();
    chk("irq_nest_mepc", mepc_o, 32'h80);
    mret_i = 1;
    cyc();
    mret_i = 0; pc_i = 32'h90;
    chk_state("irq_mret", 1'b0);
    #1;
    chk("irq_again", {31'b0, irq_ack_o}, 32'h1);
    cyc(); idle();
    chk("irq_again_mepc", mepc_o, 32'h90);
    mret_i = 1;
    cyc(); idle();
`else
    csr_wr(3'b001, 12'h304, 32'h0001_0000);
    rd("mie_ignored", 12'h304, 32'h0);
    idle(); irq_req_i = 1; pc_i = 32'h80;
    #1;
    chk("irq_off_trap", {31'b0, trap_o}, 32'h0);
    chk("irq_off_ack", {31'b0, irq_ack_o}, 32'h0);
    cyc(); idle();
    chk("irq_off_mepc", mepc_o, 32'h40);
`endif

    // stall holds off both illegal and interrupt
    idle(); stall_i = 1; irq_req_i = 1; illegal_instr_i = 1; pc_i = 32'h60;
    #1;
    chk("stall_trap", {31'b0, trap_o}, 32'h0);
    chk("stall_ack", {31'b0, irq_ack_o}, 32'h0);
    cyc();
    chk("stall_mepc", mepc_o, 32'h0000_0000 | mepc_o_exp_prev());
    stall_i = 0;
    #1;
    chk("unstall_trap", {31'b0, trap_o}, 32'h1);
    chk("unstall_ack", {31'b0, irq_ack_o}, 32'h0);
    cyc(); idle();
    chk("unstall_mepc", mepc_o, 32'h60);
    rd("unstall_mcause", 12'h342, 32'h2);
    chk_state("unstall_state", 1'b1);

    // async reset mid-cycle with a trap pending
    csr_wr(3'b001, 12'h340, 32'hDEAD_BEEF);
    rd("mscr_beef", 12'h340, 32'hDEAD_BEEF);
    @(posedge clk_i); #1;
    idle(); illegal_instr_i = 1; pc_i = 32'h200;
    #1;
    rst_ni = 0;
    #1;
    chk("arst_trap", {31'b0, trap_o}, 32'h0);
    chk("arst_mepc", mepc_o, 32'h0);
    chk("arst_mtvec", trap_pc_o, 32'h0);
    chk_state("arst_state", 1'b0);
    rd("arst_mscr", 12'h340, 32'h0);
    rd("arst_mcause", 12'h342, 32'h0);
    idle(); csr_we_i = 1; csr_op_i = 3'b001; csr_addr_i = 12'h340; wd_i = 32'h5;
    #1;
    rst_ni = 1;
    cyc(); idle();
    rd("post_rst_wr", 12'h340, 32'h5);
    chk("post_rst_mepc", mepc_o, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // mepc before the stall step: 0x90 from the last interrupt, else 0x40 from the illegal trap
  function automatic logic [31:0] mepc_o_exp_prev();
`ifdef CSR_IRQ_EN
    return 32'h90;
`else
    return 32'h40;
`endif
  endfunction

  initial begin
    #50000;
    $display("FAIL timeout observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
